islemci_bekleme: RTL
====================

// Module: islemci_bekleme
// PURPOSE
//  Parametrised successor of the multicycle RV32I-subset core. It fetches, decodes and executes
//  instructions over a single memory port with a request/ready handshake, so it tolerates any
//  number of memory wait cycles. It adds BNE, a configurable register file (RV32I or RV32E size),
//  a sticky halt on illegal or misaligned operations, and a retired-instruction counter.
//  It sits at the top of the CPU subsystem and drives the shared instruction/data memory directly.
// PARAMETERS
//  BELLEK_ADRES   32'h8000_0000  reset value of the program counter (ps)
//  YAZMAC_SAYISI  32             register count; only 16 or 32 are legal
//  SAYAC_BIT      32             width of buyruk_sayac; wraps to 0 on overflow
// PORTS
//  clk              in   1   single clock; all state updates on the rising edge
//  rst              in   1   asynchronous, active-low reset
//  bellek_adres     out  32  byte address: ps in GETIR, rs1+imm in BELLEK
//  bellek_istek     out  1   memory request; held high until the handshake completes
//  bellek_hazir     in   1   memory ready; transfer completes on an edge where istek&&hazir
//  bellek_oku_veri  in   32  read data; valid on the completing edge
//  bellek_yaz_veri  out  32  store data (value of rs2); 0 unless a SW is in progress
//  bellek_yaz       out  1   1 = write request, 0 = read; high only in BELLEK for SW
//  durdu            out  1   sticky halt flag; cleared only by reset
//  ps               out  32  current program counter (debug)
//  buyruk_sayac     out  SAYAC_BIT  number of retired instructions
// BEHAVIOUR
//  Reset (rst low, asynchronous): ps=BELLEK_ADRES; state=GETIR; all registers=0; buyruk_sayac=0;
//   durdu=0. While rst is low: bellek_istek=0, bellek_yaz=0, bellek_yaz_veri=0.
//   Reset asserted mid-transaction abandons the transaction; the memory must accept istek dropping.
//  FSM states: GETIR, COZ, YURUT, BELLEK, DUR.
//   GETIR : istek=1, adres=ps, yaz=0. On hazir, latch buyruk and go to COZ; otherwise stay.
//   COZ   : decode the instruction, read rs1 and rs2, build the immediate, go to YURUT.
//           Any undecodable opcode/funct, or an rd/rs1/rs2 index >= YAZMAC_SAYISI, goes to DUR.
//   YURUT : LUI/AUIPC/JAL/JALR/BEQ/BNE/ADDI/ADD/SUB/OR/AND/XOR: write rd, update ps, retire,
//           go to GETIR. LW/SW: compute ea=rs1+imm; if ea[1:0]!=0 go to DUR, else go to BELLEK.
//   BELLEK: istek=1, adres=ea. SW: yaz=1, yaz_veri=rs2. On hazir: LW writes rd with oku_veri,
//           SW writes nothing; ps+=4; retire; go to GETIR.
//   DUR   : istek=0, durdu=1, no further state change until reset.
//  Address, yaz and yaz_veri are stable for the whole time istek is high. hazir may already be high
//   in the first istek cycle (zero-wait access). hazir is ignored when istek is low.
//  Latency with zero-wait memory: ALU and branch instructions take 3 cycles; LW/SW take 4.
//  Retiring an instruction increments buyruk_sayac by 1, in the same edge that updates ps.
//  Arithmetic: all operations are 32-bit modulo 2^32; carries are discarded.
//   I/S/B/J immediates are sign-extended; U immediate = {buyruk[31:12],12'b0}.
//  PC rules:
//   - ALU, LUI, LW, SW and a not-taken branch: ps+=4.
//   - AUIPC: rd=ps+imm, then ps+=4.
//   - JAL: rd=ps+4, ps=ps+imm.
//   - JALR: rd=ps+4, ps=(rs1+imm)&~1.
//   - BEQ/BNE taken: ps=ps+imm.
//  Misaligned target (new ps[1:0]!=0) on a jump or taken branch: go to DUR; ps and rd keep their
//   old values and the instruction does not retire.
//  x0 always reads 0; writes to rd=0 are discarded. JALR with rd==rs1 uses the old rs1 value.
// TESTING
//  1. rst low, then high; hazir=1 -> first istek at adres 0x8000_0000; istek=0 while rst low.
//  2. ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2; SUB x4,x1,x2 -> x3=12, x4=0xFFFF_FFFE, sayac=4.
//  3. Wait 3 cycles on the LW fetch and 2 on its data (SW x3,0(x0)+0x100 then LW x5,0x100) ->
//     adres and yaz_veri stable while istek; x5=12; 4-cycle LW with zero wait, +wait cycles.
//  4. BNE x1,x1,+8 is not taken (ps+=4); BEQ x1,x1,-4 is taken; JALR x1,x1,3 -> x1=ps+4, bit0
//     cleared; a JAL with offset 2 -> DUR, durdu=1, ps unchanged.
//  5. YAZMAC_SAYISI=16: ADD x17,x1,x2 -> DUR with no register write; ADDI x0,x0,9 -> x0 stays 0.
//  6. Drop rst during BELLEK of a SW with hazir=0 -> immediate reset values; no write issued.

Source files
------------

// File: rtl/islemci_bekleme.sv
// islemci_bekleme: multicycle RV32I-subset core (LUI, AUIPC, JAL, JALR, BEQ, BNE, ADDI,
// ADD, SUB, OR, AND, XOR, LW, SW) with one shared memory port using an istek/hazir handshake.
// Any number of memory wait cycles is tolerated. Illegal or misaligned operations park the core
// in a sticky halt state that only reset leaves.
module islemci_bekleme #(
  parameter logic [31:0] BELLEK_ADRES  = 32'h8000_0000,
  parameter int          YAZMAC_SAYISI = 32,   // 16 (RV32E) or 32 (RV32I)
  parameter int          SAYAC_BIT     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [31:0]          bellek_adres,
  output logic                 bellek_istek,
  input  logic                 bellek_hazir,
  input  logic [31:0]          bellek_oku_veri,
  output logic [31:0]          bellek_yaz_veri,
  output logic                 bellek_yaz,
  output logic                 durdu,
  output logic [31:0]          ps,
  output logic [SAYAC_BIT-1:0] buyruk_sayac
);

  // Register file index width; the upper index bit is only meaningful with 32 registers.
  localparam int         IW = (YAZMAC_SAYISI == 16) ? 4 : 5;
  localparam logic [5:0] YS = 6'(YAZMAC_SAYISI);

  typedef enum logic [2:0] {GETIR, COZ, YURUT, BELLEK, DUR} durum_t;

  typedef enum logic [3:0] {
    B_LUI, B_AUIPC, B_JAL, B_JALR, B_BEQ, B_BNE, B_ADDI,
    B_ADD, B_SUB, B_OR, B_AND, B_XOR, B_LW, B_SW, B_GECERSIZ
  } tur_t;

  durum_t durum, sonraki;
  tur_t   tur;

  logic [31:0] buyruk;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic        kullan_rd, kullan_rs1, kullan_rs2, indeks_hatali;

  logic [31:0] yazmac [YAZMAC_SAYISI];
  logic [31:0] rs1_deger, rs2_deger;
  logic [31:0] imm_c, imm_r, rs1_r, rs2_r, ea_r;

  logic [31:0] sonuc, hedef, ea_c;
  logic        rd_yaz, sicrama, hedef_hizasiz, bellek_buyruk;

  logic        istek_ic, yaz_ic;
  logic [31:0] adres_ic, yaz_veri_ic;

  assign opcode = buyruk[6:0];
  assign funct3 = buyruk[14:12];
  assign funct7 = buyruk[31:25];
  assign rd_a   = buyruk[11:7];
  assign rs1_a  = buyruk[19:15];
  assign rs2_a  = buyruk[24:20];

  // Decode the latched instruction: kind, which register fields it uses, and its immediate.
  always_comb begin
    tur        = B_GECERSIZ;
    imm_c      = 32'd0;
    kullan_rd  = 1'b0;
    kullan_rs1 = 1'b0;
    kullan_rs2 = 1'b0;
    case (opcode)
      7'b0110111: begin
        tur       = B_LUI;
        kullan_rd = 1'b1;
        imm_c     = {buyruk[31:12], 12'b0};
      end
      7'b0010111: begin
        tur       = B_AUIPC;
        kullan_rd = 1'b1;
        imm_c     = {buyruk[31:12], 12'b0};
      end
      7'b1101111: begin
        tur       = B_JAL;
        kullan_rd = 1'b1;
        imm_c     = {{11{buyruk[31]}}, buyruk[31], buyruk[19:12], buyruk[20],
                     buyruk[30:21], 1'b0};
      end
      7'b1100111: begin
        if (funct3 == 3'b000) tur = B_JALR;
        kullan_rd  = 1'b1;
        kullan_rs1 = 1'b1;
        imm_c      = {{20{buyruk[31]}}, buyruk[31:20]};
      end
      7'b1100011: begin
        if (funct3 == 3'b000)      tur = B_BEQ;
        else if (funct3 == 3'b001) tur = B_BNE;
        kullan_rs1 = 1'b1;
        kullan_rs2 = 1'b1;
        imm_c      = {{19{buyruk[31]}}, buyruk[31], buyruk[7], buyruk[30:25],
                      buyruk[11:8], 1'b0};
      end
      7'b0000011: begin
        if (funct3 == 3'b010) tur = B_LW;
        kullan_rd  = 1'b1;
        kullan_rs1 = 1'b1;
        imm_c      = {{20{buyruk[31]}}, buyruk[31:20]};
      end
      7'b0100011: begin
        if (funct3 == 3'b010) tur = B_SW;
        kullan_rs1 = 1'b1;
        kullan_rs2 = 1'b1;
        imm_c      = {{20{buyruk[31]}}, buyruk[31:25], buyruk[11:7]};
      end
      7'b0010011: begin
        if (funct3 == 3'b000) tur = B_ADDI;
        kullan_rd  = 1'b1;
        kullan_rs1 = 1'b1;
        imm_c      = {{20{buyruk[31]}}, buyruk[31:20]};
      end
      7'b0110011: begin
        kullan_rd  = 1'b1;
        kullan_rs1 = 1'b1;
        kullan_rs2 = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: tur = B_ADD;
          {7'b0100000, 3'b000}: tur = B_SUB;
          {7'b0000000, 3'b110}: tur = B_OR;
          {7'b0000000, 3'b111}: tur = B_AND;
          {7'b0000000, 3'b100}: tur = B_XOR;
          default:              tur = B_GECERSIZ;
        endcase
      end
      default: tur = B_GECERSIZ;
    endcase
  end

  // A used register field outside the configured register file is treated as illegal.
  assign indeks_hatali = (kullan_rd  && ({1'b0, rd_a}  >= YS)) ||
                         (kullan_rs1 && ({1'b0, rs1_a} >= YS)) ||
                         (kullan_rs2 && ({1'b0, rs2_a} >= YS));

  // x0 reads as zero; out-of-range indices never get past decode, so the slice is safe.
  assign rs1_deger = (rs1_a == 5'd0) ? 32'd0 : yazmac[rs1_a[IW-1:0]];
  assign rs2_deger = (rs2_a == 5'd0) ? 32'd0 : yazmac[rs2_a[IW-1:0]];

  assign bellek_buyruk = (tur == B_LW) || (tur == B_SW);
  assign ea_c          = rs1_r + imm_r;

  // Execute: result for rd, next pc, and whether the next pc is a jump target needing a check.
  always_comb begin
    sonuc   = 32'd0;
    hedef   = ps + 32'd4;
    rd_yaz  = 1'b0;
    sicrama = 1'b0;
    case (tur)
      B_LUI:   begin sonuc = imm_r;          rd_yaz = 1'b1; end
      B_AUIPC: begin sonuc = ps + imm_r;     rd_yaz = 1'b1; end
      B_JAL: begin
        sonuc   = ps + 32'd4;
        rd_yaz  = 1'b1;
        hedef   = ps + imm_r;
        sicrama = 1'b1;
      end
      B_JALR: begin
        sonuc   = ps + 32'd4;
        rd_yaz  = 1'b1;
        hedef   = (rs1_r + imm_r) & ~32'd1;
        sicrama = 1'b1;
      end
      B_BEQ: begin
        if (rs1_r == rs2_r) begin
          hedef   = ps + imm_r;
          sicrama = 1'b1;
        end
      end
      B_BNE: begin
        if (rs1_r != rs2_r) begin
          hedef   = ps + imm_r;
          sicrama = 1'b1;
        end
      end
      B_ADDI:  begin sonuc = rs1_r + imm_r;  rd_yaz = 1'b1; end
      B_ADD:   begin sonuc = rs1_r + rs2_r;  rd_yaz = 1'b1; end
      B_SUB:   begin sonuc = rs1_r - rs2_r;  rd_yaz = 1'b1; end
      B_OR:    begin sonuc = rs1_r | rs2_r;  rd_yaz = 1'b1; end
      B_AND:   begin sonuc = rs1_r & rs2_r;  rd_yaz = 1'b1; end
      B_XOR:   begin sonuc = rs1_r ^ rs2_r;  rd_yaz = 1'b1; end
      default: begin sonuc = 32'd0;          rd_yaz = 1'b0; end
    endcase
  end

  assign hedef_hizasiz = sicrama && (hedef[1:0] != 2'b00);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) durum <= GETIR;
    else      durum <= sonraki;
  end

  // Next state and memory-port outputs; address and write data come from registers held
  // constant for the whole request.
  always_comb begin
    sonraki     = durum;
    istek_ic    = 1'b0;
    yaz_ic      = 1'b0;
    adres_ic    = ps;
    yaz_veri_ic = 32'd0;
    case (durum)
      GETIR: begin
        istek_ic = 1'b1;
        if (bellek_hazir) sonraki = COZ;
      end
      COZ: begin
        if (tur == B_GECERSIZ || indeks_hatali) sonraki = DUR;
        else                                    sonraki = YURUT;
      end
      YURUT: begin
        if (bellek_buyruk) sonraki = (ea_c[1:0] != 2'b00) ? DUR : BELLEK;
        else               sonraki = hedef_hizasiz ? DUR : GETIR;
      end
      BELLEK: begin
        istek_ic = 1'b1;
        adres_ic = ea_r;
        if (tur == B_SW) begin
          yaz_ic      = 1'b1;
          yaz_veri_ic = rs2_r;
        end
        if (bellek_hazir) sonraki = GETIR;
      end
      DUR:     sonraki = DUR;
      default: sonraki = GETIR;
    endcase
  end

  // The request lines are forced low while reset is held, which also abandons any transfer.
  assign bellek_istek    = rst & istek_ic;
  assign bellek_yaz      = rst & yaz_ic;
  assign bellek_yaz_veri = rst ? yaz_veri_ic : 32'd0;
  assign bellek_adres    = adres_ic;
  assign durdu           = (durum == DUR);

  // Datapath: fetch latch, operand capture, register writeback, pc and retire counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps           <= BELLEK_ADRES;
      buyruk_sayac <= '0;
      buyruk       <= 32'd0;
      imm_r        <= 32'd0;
      rs1_r        <= 32'd0;
      rs2_r        <= 32'd0;
      ea_r         <= 32'd0;
      for (int i = 0; i < YAZMAC_SAYISI; i++) yazmac[i] <= 32'd0;
    end else begin
      case (durum)
        GETIR: begin
          if (bellek_hazir) buyruk <= bellek_oku_veri;
        end
        COZ: begin
          rs1_r <= rs1_deger;
          rs2_r <= rs2_deger;
          imm_r <= imm_c;
        end
        YURUT: begin
          if (bellek_buyruk) begin
            ea_r <= ea_c;
          end else if (!hedef_hizasiz) begin
            if (rd_yaz && rd_a != 5'd0) yazmac[rd_a[IW-1:0]] <= sonuc;
            ps           <= hedef;
            buyruk_sayac <= buyruk_sayac + {{(SAYAC_BIT-1){1'b0}}, 1'b1};
          end
        end
        BELLEK: begin
          if (bellek_hazir) begin
            if (tur == B_LW && rd_a != 5'd0) yazmac[rd_a[IW-1:0]] <= bellek_oku_veri;
            ps           <= ps + 32'd4;
            buyruk_sayac <= buyruk_sayac + {{(SAYAC_BIT-1){1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
